// File: rtl/mem_responder.sv
// mem_responder: req/ack memory slave with programmable wait states,
// byte/half/word little-endian access and error reporting.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for req; latches the request when req=1
// ST_WAIT | wait states; cntQ counts down to 0, then RESP
// ST_RESP | one-cycle ack; err/rdata valid; always returns to IDLE
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } stateE;

  stateE stateQ, stateD;

  logic [3:0]  cntQ;
  logic        weQ;
  logic [1:0]  sizeQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic        errQ;
  logic [31:0] rdataQ;

  logic [7:0] mem [DEPTH];

  logic              acceptReq;
  logic              enterResp;
  logic              curWe;
  logic [1:0]        curSize;
  logic [31:0]       curAddr;
  logic [31:0]       curWdata;
  logic              accErr;
  logic [3:0]        laneEn;
  logic [ADDR_W-1:0] laneAddr [4];
  logic [31:0]       readWord;

  // The wait counter is only 4 bits; larger settings cannot be honoured.
  if (WAIT_CYC > 15 || WAIT_CYC < 0) begin : gBadWaitCyc
    always_ff @(posedge clock) begin
      $error("mem_responder: WAIT_CYC=%0d is outside 0..15", WAIT_CYC);
    end
  end

  // Control events: acceptance in IDLE, and the edge that lands in RESP.
  always_comb begin
    acceptReq = (stateQ == ST_IDLE) && req;
    enterResp = 1'b0;
    if (stateQ == ST_IDLE && req && WAIT_CYC == 0) enterResp = 1'b1;
    if (stateQ == ST_WAIT && cntQ == 4'd0)         enterResp = 1'b1;
  end

  // With zero wait states RESP is entered on the accepting edge, before the
  // latches hold the request, so the live inputs are used while in IDLE.
  always_comb begin
    if (stateQ == ST_IDLE) begin
      curWe    = we;
      curSize  = size;
      curAddr  = addr;
      curWdata = wdata;
    end else begin
      curWe    = weQ;
      curSize  = sizeQ;
      curAddr  = addrQ;
      curWdata = wdataQ;
    end
  end

  // Access checks and byte-lane selection for the current request.
  always_comb begin
    accErr = 1'b0;
    laneEn = 4'b0000;
    case (curSize)
      SZ_WORD: begin
        laneEn = 4'b1111;
        if (curAddr[1:0] != 2'b00) accErr = 1'b1;
      end
      SZ_HALF: begin
        laneEn = 4'b0011;
        if (curAddr[0] != 1'b0) accErr = 1'b1;
      end
      SZ_BYTE: begin
        laneEn = 4'b0001;
      end
      default: begin
        accErr = 1'b1;
      end
    endcase
    // Accesses are aligned, so an in-range base implies an in-range last byte.
    if ((curAddr >> ADDR_W) != 32'd0) accErr = 1'b1;
  end

  // Per-lane array addresses and the zero-extended read word.
  always_comb begin
    readWord = '0;
    for (int i = 0; i < 4; i++) begin
      laneAddr[i] = curAddr[ADDR_W-1:0] + ADDR_W'(i);
      if (laneEn[i]) readWord[8*i +: 8] = mem[laneAddr[i]];
    end
  end

  // Next-state and output decode.
  always_comb begin
    stateD = stateQ;
    busy   = 1'b0;
    ack    = 1'b0;
    err    = 1'b0;
    rdata  = '0;
    case (stateQ)
      ST_IDLE: begin
        if (req) stateD = (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cntQ == 4'd0) stateD = ST_RESP;
      end
      ST_RESP: begin
        busy   = 1'b1;
        ack    = 1'b1;
        err    = errQ;
        rdata  = rdataQ;
        stateD = ST_IDLE;
      end
      default: begin
        stateD = ST_IDLE;
      end
    endcase
  end

  // State, request latches, wait down-counter and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= ST_IDLE;
      cntQ   <= 4'd0;
      errQ   <= 1'b0;
      rdataQ <= '0;
      weQ    <= 1'b0;
      sizeQ  <= 2'b00;
      addrQ  <= '0;
      wdataQ <= '0;
    end else begin
      stateQ <= stateD;
      if (acceptReq) begin
        weQ    <= we;
        sizeQ  <= size;
        addrQ  <= addr;
        wdataQ <= wdata;
        cntQ   <= CNT_LOAD;
      end else if (stateQ == ST_WAIT && cntQ != 4'd0) begin
        cntQ <= cntQ - 4'd1;
      end
      if (enterResp) begin
        errQ   <= accErr;
        rdataQ <= (accErr || curWe) ? 32'd0 : readWord;
      end
    end
  end

  // Byte array write; contents survive reset, pending writes do not.
  always_ff @(posedge clock) begin
    if (!reset && enterResp && curWe && !accErr) begin
      for (int i = 0; i < 4; i++) begin
        if (laneEn[i]) mem[laneAddr[i]] <= curWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: one instance with one wait state,
// one with zero wait states.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        reqFast = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic        busy, ack, err;
  logic [31:0] rdata;
  logic        busyFast, ackFast, errFast;
  logic [31:0] rdataFast;

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_W(8), .WAIT_CYC(1)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYC(0)) dutFast (
    .clock(clock), .reset(reset), .req(reqFast), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .busy(busyFast), .ack(ackFast), .err(errFast),
    .rdata(rdataFast)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One complete access; checks latency (edges after acceptance), err, rdata,
  // and that the responder is idle on the following cycle.
  task automatic doAccess(input bit useFast, input bit isWr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic expErr, input logic [31:0] expRd, input string tag);
    int n;
    @(negedge clock);
    we = isWr; size = sz; addr = a; wdata = wd;
    if (useFast) reqFast = 1'b1; else req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0; reqFast = 1'b0;
    n = 0;
    while (!(useFast ? ackFast : ack) && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    checkVal({tag, " latency"}, 32'(n), useFast ? 32'd0 : 32'd1);
    checkVal({tag, " err"}, {31'd0, useFast ? errFast : err}, {31'd0, expErr});
    checkVal({tag, " rdata"}, useFast ? rdataFast : rdata, expRd);
    @(posedge clock); #1;
    checkVal({tag, " idle busy"}, {31'd0, useFast ? busyFast : busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] busyPat;
    int ackCount;
    busyPat = 8'b0001_1011;

    repeat (3) @(posedge clock);
    #1;
    checkVal("reset busy", {31'd0, busy}, 32'd0);
    checkVal("reset ack", {31'd0, ack}, 32'd0);
    checkVal("reset err", {31'd0, err}, 32'd0);
    checkVal("reset rdata", rdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Word write then read
    doAccess(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 32'd0, "wr word 10");
    doAccess(0, 0, 2'b00, 32'h10, 32'd0, 0, 32'hDEADBEEF, "rd word 10");

    // Byte write, half and word read
    doAccess(0, 1, 2'b10, 32'h11, 32'h000000AA, 0, 32'd0, "wr byte 11");
    doAccess(0, 0, 2'b01, 32'h10, 32'd0, 0, 32'h0000AAEF, "rd half 10");
    doAccess(0, 0, 2'b00, 32'h10, 32'd0, 0, 32'hDEADAAEF, "rd word 10b");

    // Misaligned and illegal size
    doAccess(0, 0, 2'b00, 32'h12, 32'd0, 1, 32'd0, "rd word 12 mis");
    doAccess(0, 1, 2'b01, 32'h13, 32'h00001234, 1, 32'd0, "wr half 13 mis");
    doAccess(0, 1, 2'b11, 32'h10, 32'h11223344, 1, 32'd0, "size 11");
    doAccess(0, 0, 2'b00, 32'h10, 32'd0, 0, 32'hDEADAAEF, "rd word 10c");

    // Out of range and top-of-array
    doAccess(0, 0, 2'b00, 32'h100, 32'd0, 1, 32'd0, "rd word 100");
    doAccess(0, 1, 2'b00, 32'hFC, 32'hCAFEF00D, 0, 32'd0, "wr word fc");
    doAccess(0, 0, 2'b00, 32'hFC, 32'd0, 0, 32'hCAFEF00D, "rd word fc");
    doAccess(0, 0, 2'b10, 32'hFF, 32'd0, 0, 32'h000000CA, "rd byte ff");

    // req held for 6 edges: two accepted, busy pattern 1,1,0,1,1,0,0,0
    @(negedge clock);
    we = 1'b0; size = 2'b00; addr = 32'h10; req = 1'b1;
    ackCount = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      if (k == 5) req = 1'b0;
      checkVal($sformatf("burst busy k%0d", k), {31'd0, busy}, {31'd0, busyPat[k]});
      if (ack) begin
        ackCount++;
        checkVal($sformatf("burst rdata k%0d", k), rdata, 32'hDEADAAEF);
      end
    end
    checkVal("burst ack count", 32'(ackCount), 32'd2);

    // Reset during WAIT drops the pending write
    doAccess(0, 1, 2'b00, 32'h20, 32'h55AA55AA, 0, 32'd0, "wr word 20 old");
    @(negedge clock);
    we = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    checkVal("pending busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checkVal("post-reset busy", {31'd0, busy}, 32'd0);
    checkVal("post-reset ack", {31'd0, ack}, 32'd0);
    checkVal("post-reset err", {31'd0, err}, 32'd0);
    checkVal("post-reset rdata", rdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    doAccess(0, 0, 2'b00, 32'h20, 32'd0, 0, 32'h55AA55AA, "rd word 20");

    // Reset wins over a simultaneous req
    @(negedge clock);
    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clock); #1;
    checkVal("reset vs req busy", {31'd0, busy}, 32'd0);
    req = 1'b0;
    @(posedge clock); #1;
    checkVal("reset vs req busy2", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Zero wait states: ack on the cycle right after acceptance
    doAccess(1, 1, 2'b00, 32'h40, 32'h0BADF00D, 0, 32'd0, "fast wr 40");
    doAccess(1, 0, 2'b00, 32'h40, 32'd0, 0, 32'h0BADF00D, "fast rd 40");
    doAccess(1, 0, 2'b01, 32'h42, 32'd0, 0, 32'h00000BAD, "fast rd half 42");
    doAccess(1, 0, 2'b01, 32'h41, 32'd0, 1, 32'd0, "fast rd half 41");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
